hazard_ctrl: RTL and testbench

- Pipeline hazard controller for the 5-stage MIPS core. Branch compare is resolved in ID, and a data memory may take several cycles.
- Generates PC/IF_ID write enables, the IF_ID flush, the ID_EX bubble and the EX_MEM/MEM_WB freeze.
- Handles load-use, branch-operand and memory-wait hazards.
- Works alongside the forwarding unit and keeps saturating stall/flush performance counters.

---
 rtl/hazard_ctrl_pkg.sv | 18 +
 rtl/hazard_ctrl_sat_counter.sv | 23 ++
 rtl/hazard_ctrl.sv | 98 +++++++++
 tb/tb_hazard_ctrl.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_ctrl_pkg.sv
// Shared pipeline types for the hazard controller: FSM states and register-match helper.
package pipe_pkg;

    typedef enum logic {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } state_t;

    localparam logic [4:0] REG_ZERO = 5'd0;

    // A producer destination hits a consumer source only when it is not $zero.
    function automatic logic reg_hit(input logic [4:0] dst,
                                     input logic [4:0] src_a,
                                     input logic [4:0] src_b);
        return (dst != REG_ZERO) && ((dst == src_a) || (dst == src_b));
    endfunction

endpackage

// File: rtl/hazard_ctrl_sat_counter.sv
// Saturating up-counter with synchronous active-high reset; holds at all-ones.
module sat_counter #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] q
);

    logic [W-1:0] r_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_q <= '0;
        end else if (inc && (r_q != {W{1'b1}})) begin
            r_q <= r_q + W'(1);
        end
    end

    assign q = r_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use / branch-operand stalls, taken-branch flush,
// multi-cycle data-memory freeze, plus saturating stall and flush counters.
module hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       IF_ID_rs,
    input  logic [4:0]       IF_ID_rt,
    input  logic             ID_branch,
    input  logic             ID_jump,
    input  logic             branch_taken,
    input  logic             ID_EX_mem_read,
    input  logic             ID_EX_reg_write,
    input  logic [4:0]       ID_EX_rd,
    input  logic             EX_MEM_mem_read,
    input  logic             EX_MEM_mem_op,
    input  logic [4:0]       EX_MEM_rd,
    input  logic             dmem_ready,
    output logic             pc_write,
    output logic             IF_ID_write,
    output logic             IF_ID_flush,
    output logic             ID_EX_bubble,
    output logic             back_write,
    output logic             busy,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    state_t r_state;
    logic   w_load_use;
    logic   w_br_ex;
    logic   w_br_mem;
    logic   w_hz;
    logic   w_freeze;

    // Hazard detection and memory-wait condition.
    always_comb begin
        w_load_use = ID_EX_mem_read && reg_hit(ID_EX_rd, IF_ID_rs, IF_ID_rt);
        w_br_ex    = ID_branch && ID_EX_reg_write && reg_hit(ID_EX_rd, IF_ID_rs, IF_ID_rt);
        w_br_mem   = ID_branch && EX_MEM_mem_read && reg_hit(EX_MEM_rd, IF_ID_rs, IF_ID_rt);
        w_hz       = w_load_use || w_br_ex || w_br_mem;
        w_freeze   = (r_state == MEM_WAIT) ? !dmem_ready : (EX_MEM_mem_op && !dmem_ready);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= RUN;
        end else begin
            case (r_state)
                RUN:      if (w_freeze)   r_state <= MEM_WAIT;
                MEM_WAIT: if (dmem_ready) r_state <= RUN;
                default:                  r_state <= RUN;
            endcase
        end
    end

    // Precedence: memory freeze, then data hazard, then control-flow flush.
    always_comb begin
        pc_write     = 1'b1;
        IF_ID_write  = 1'b1;
        IF_ID_flush  = 1'b0;
        ID_EX_bubble = 1'b0;
        back_write   = 1'b1;
        busy         = 1'b0;
        if (!rst) begin
            busy = (r_state == MEM_WAIT);
            if (w_freeze) begin
                pc_write    = 1'b0;
                IF_ID_write = 1'b0;
                back_write  = 1'b0;
            end else if (w_hz) begin
                pc_write     = 1'b0;
                IF_ID_write  = 1'b0;
                ID_EX_bubble = 1'b1;
            end else begin
                IF_ID_flush = ID_jump || (ID_branch && branch_taken);
            end
        end
    end

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk (clk),
        .rst (rst),
        .inc (!pc_write),
        .q   (stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk (clk),
        .rst (rst),
        .inc (IF_ID_flush),
        .q   (flush_cnt)
    );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: directed scenarios then random traffic vs a reference model.
module tb_hazard_ctrl;

    localparam int unsigned CNT_W   = 16;
    localparam int unsigned SMALL_W = 3;

    typedef struct {
        logic       rst;
        logic [4:0] rs, rt;
        logic       br, jmp, taken;
        logic       ex_mr, ex_rw;
        logic [4:0] ex_rd;
        logic       mem_mr, mem_op;
        logic [4:0] mem_rd;
        logic       rdy;
    } stim_t;

    typedef struct {
        logic pc, ifid, flush, bubble, bw, busy;
        int   sc, fc, sc_s, fc_s;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [4:0] IF_ID_rs = '0, IF_ID_rt = '0, ID_EX_rd = '0, EX_MEM_rd = '0;
    logic ID_branch = 0, ID_jump = 0, branch_taken = 0, ID_EX_mem_read = 0, ID_EX_reg_write = 0;
    logic EX_MEM_mem_read = 0, EX_MEM_mem_op = 0, dmem_ready = 1;
    logic pc_write, IF_ID_write, IF_ID_flush, ID_EX_bubble, back_write, busy;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;
    logic s_pc, s_ifid, s_flush, s_bubble, s_bw, s_busy;
    logic [SMALL_W-1:0] s_stall_cnt, s_flush_cnt;

    always #5 clk = ~clk;

    hazard_ctrl #(.CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .IF_ID_rs(IF_ID_rs), .IF_ID_rt(IF_ID_rt),
        .ID_branch(ID_branch), .ID_jump(ID_jump), .branch_taken(branch_taken),
        .ID_EX_mem_read(ID_EX_mem_read), .ID_EX_reg_write(ID_EX_reg_write), .ID_EX_rd(ID_EX_rd),
        .EX_MEM_mem_read(EX_MEM_mem_read), .EX_MEM_mem_op(EX_MEM_mem_op), .EX_MEM_rd(EX_MEM_rd),
        .dmem_ready(dmem_ready), .pc_write(pc_write), .IF_ID_write(IF_ID_write),
        .IF_ID_flush(IF_ID_flush), .ID_EX_bubble(ID_EX_bubble), .back_write(back_write),
        .busy(busy), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    // Narrow-counter copy so saturation is reached within a short run.
    hazard_ctrl #(.CNT_W(SMALL_W)) dut_small (
        .clk(clk), .rst(rst), .IF_ID_rs(IF_ID_rs), .IF_ID_rt(IF_ID_rt),
        .ID_branch(ID_branch), .ID_jump(ID_jump), .branch_taken(branch_taken),
        .ID_EX_mem_read(ID_EX_mem_read), .ID_EX_reg_write(ID_EX_reg_write), .ID_EX_rd(ID_EX_rd),
        .EX_MEM_mem_read(EX_MEM_mem_read), .EX_MEM_mem_op(EX_MEM_mem_op), .EX_MEM_rd(EX_MEM_rd),
        .dmem_ready(dmem_ready), .pc_write(s_pc), .IF_ID_write(s_ifid),
        .IF_ID_flush(s_flush), .ID_EX_bubble(s_bubble), .back_write(s_bw),
        .busy(s_busy), .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt)
    );

    int   total = 0;
    int   bad   = 0;
    exp_t exp_q[$];

    // Reference model state: whether the memory is holding the pipe, and counter values.
    bit m_waiting = 0;
    int m_sc = 0, m_fc = 0, m_sc_s = 0, m_fc_s = 0;

    function automatic bit hits(input logic [4:0] dst, input logic [4:0] a, input logic [4:0] b);
        return (dst != 5'd0) && (dst == a || dst == b);
    endfunction

    function automatic int sat_inc(input int v, input bit inc, input int w);
        int max_v;
        max_v = (1 << w) - 1;
        return (inc && v < max_v) ? v + 1 : v;
    endfunction

    function automatic stim_t nop();
        stim_t s;
        s = '{rst: 0, rs: 0, rt: 0, br: 0, jmp: 0, taken: 0, ex_mr: 0, ex_rw: 0,
              ex_rd: 0, mem_mr: 0, mem_op: 0, mem_rd: 0, rdy: 1};
        return s;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, expv);
        end
    endtask

    // Apply one cycle of stimulus and queue the response the model predicts for it.
    task automatic drive(input stim_t s);
        exp_t e;
        bit   frozen, hz;
        @(posedge clk);
        #1;
        rst = s.rst; IF_ID_rs = s.rs; IF_ID_rt = s.rt; ID_branch = s.br; ID_jump = s.jmp;
        branch_taken = s.taken; ID_EX_mem_read = s.ex_mr; ID_EX_reg_write = s.ex_rw;
        ID_EX_rd = s.ex_rd; EX_MEM_mem_read = s.mem_mr; EX_MEM_mem_op = s.mem_op;
        EX_MEM_rd = s.mem_rd; dmem_ready = s.rdy;

        frozen = m_waiting ? !s.rdy : (s.mem_op && !s.rdy);
        hz = (s.ex_mr && hits(s.ex_rd, s.rs, s.rt))
           || (s.br && s.ex_rw && hits(s.ex_rd, s.rs, s.rt))
           || (s.br && s.mem_mr && hits(s.mem_rd, s.rs, s.rt));
        e.sc = m_sc; e.fc = m_fc; e.sc_s = m_sc_s; e.fc_s = m_fc_s;
        if (s.rst) begin
            e.pc = 1; e.ifid = 1; e.bw = 1; e.bubble = 0; e.flush = 0; e.busy = 0;
        end else begin
            e.busy   = m_waiting;
            e.pc     = !(frozen || hz);
            e.ifid   = e.pc;
            e.bw     = !frozen;
            e.bubble = !frozen && hz;
            e.flush  = !frozen && !hz && (s.jmp || (s.br && s.taken));
        end
        exp_q.push_back(e);

        if (s.rst) begin
            m_waiting = 0; m_sc = 0; m_fc = 0; m_sc_s = 0; m_fc_s = 0;
        end else begin
            m_waiting = frozen;
            m_sc   = sat_inc(m_sc,   !e.pc,   CNT_W);
            m_fc   = sat_inc(m_fc,   e.flush, CNT_W);
            m_sc_s = sat_inc(m_sc_s, !e.pc,   SMALL_W);
            m_fc_s = sat_inc(m_fc_s, e.flush, SMALL_W);
        end
    endtask

    // Monitor: compare every presented cycle against the oldest queued expectation.
    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("pc_write",     32'(pc_write),     32'(e.pc));
            check("IF_ID_write",  32'(IF_ID_write),  32'(e.ifid));
            check("IF_ID_flush",  32'(IF_ID_flush),  32'(e.flush));
            check("ID_EX_bubble", 32'(ID_EX_bubble), 32'(e.bubble));
            check("back_write",   32'(back_write),   32'(e.bw));
            check("busy",         32'(busy),         32'(e.busy));
            check("stall_cnt",    32'(stall_cnt),    e.sc);
            check("flush_cnt",    32'(flush_cnt),    e.fc);
            check("stall_cnt_w3", 32'(s_stall_cnt),  e.sc_s);
            check("flush_cnt_w3", 32'(s_flush_cnt),  e.fc_s);
        end
    end

    initial begin
        stim_t s;
        repeat (2) @(posedge clk);

        // Reset state
        s = nop(); s.rst = 1;
        drive(s);
        drive(nop());

        // Load-use: lw $2 in EX, rs=2 in ID
        s = nop(); s.ex_mr = 1; s.ex_rw = 1; s.ex_rd = 2; s.rs = 2;
        drive(s);
        drive(nop());

        // Branch after load: br_ex then br_mem, taken ignored during stalls
        s = nop(); s.br = 1; s.taken = 1; s.rs = 3; s.ex_mr = 1; s.ex_rw = 1; s.ex_rd = 3;
        drive(s);
        s = nop(); s.br = 1; s.taken = 1; s.rs = 3; s.mem_mr = 1; s.mem_op = 1; s.mem_rd = 3;
        drive(s);
        s = nop(); s.br = 1; s.taken = 1; s.rs = 3;
        drive(s);

        // Branch without hazard, not taken; then jump
        s = nop(); s.br = 1; s.rs = 4; s.rt = 5;
        drive(s);
        s = nop(); s.jmp = 1;
        drive(s);

        // Store waiting three cycles on memory
        s = nop(); s.mem_op = 1; s.rdy = 0;
        repeat (3) drive(s);
        s.rdy = 1;
        drive(s);
        drive(nop());

        // $zero never hazards
        s = nop(); s.ex_mr = 1; s.ex_rw = 1; s.ex_rd = 0; s.rs = 0; s.rt = 0;
        drive(s);

        // Reset during memory wait
        s = nop(); s.mem_op = 1; s.rdy = 0;
        repeat (2) drive(s);
        s.rst = 1;
        drive(s);
        drive(nop());

        // Long load-use stall drives the narrow counters into saturation
        s = nop(); s.ex_mr = 1; s.ex_rd = 7; s.rt = 7;
        repeat (12) drive(s);
        s = nop(); s.jmp = 1;
        repeat (10) drive(s);

        // Random traffic over a small register set
        for (int i = 0; i < 3000; i++) begin
            s.rst    = ($urandom_range(0, 199) == 0);
            s.rs     = 5'($urandom_range(0, 3));
            s.rt     = 5'($urandom_range(0, 3));
            s.br     = 1'($urandom_range(0, 1));
            s.jmp    = !s.br && ($urandom_range(0, 7) == 0);
            s.taken  = 1'($urandom_range(0, 1));
            s.ex_mr  = ($urandom_range(0, 3) == 0);
            s.ex_rw  = s.ex_mr || 1'($urandom_range(0, 1));
            s.ex_rd  = 5'($urandom_range(0, 3));
            s.mem_mr = ($urandom_range(0, 3) == 0);
            s.mem_op = s.mem_mr || ($urandom_range(0, 3) == 0);
            s.mem_rd = 5'($urandom_range(0, 3));
            s.rdy    = ($urandom_range(0, 3) != 0);
            drive(s);
        end
        drive(nop());

        @(posedge clk);
        @(posedge clk);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
